// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester front end for a shared combinational ALU with an
//            IDLE/EXEC/RESP transaction FSM and a valid/ready response port.
// Config   : define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins);
//            otherwise arbitration is round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [5:0]     req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_c,
  output logic           rsp_zero,
  output logic           rsp_err,
  output logic [2:0]     alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_c,
  input  logic           alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [2:0]     lat_op;
  logic [W-1:0]   lat_a;
  logic [W-1:0]   lat_b;
  logic           lat_id;
  logic           grant_id;
  logic           accept;
  logic           lat_illegal;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant_id = ~req_valid[0];
`else
  logic last_grant;

  always_comb begin
    if (&req_valid) grant_id = ~last_grant;
    else            grant_id = req_valid[1];
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant_id;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          req_ready = grant_id ? 2'b10 : 2'b01;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_op <= 3'd0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_id <= 1'b0;
    end else if (accept) begin
      lat_op <= grant_id ? req_op[5:3]     : req_op[2:0];
      lat_a  <= grant_id ? req_a[2*W-1:W]  : req_a[W-1:0];
      lat_b  <= grant_id ? req_b[2*W-1:W]  : req_b[W-1:0];
      lat_id <= grant_id;
    end
  end

  assign lat_illegal = (lat_op == 3'd7);

  // ALU inputs come straight from the latches so they stay quiet while idle.
  assign alu_op    = lat_illegal ? 3'd0 : lat_op;
  assign alu_a     = lat_a;
  assign alu_b     = lat_b;
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= 1'b0;
      rsp_c    <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id   <= lat_id;
      rsp_c    <= lat_illegal ? '0 : alu_c;
      rsp_zero <= lat_illegal ? 1'b0 : alu_zero;
      rsp_err  <= lat_illegal;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a response scoreboard.
`default_nettype none

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_c;
  logic        rsp_zero;
  logic        rsp_err;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_c;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_arbiter #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (alu_op)
      3'd0:    alu_c = alu_a & alu_b;
      3'd1:    alu_c = alu_a | alu_b;
      3'd2:    alu_c = alu_a + alu_b;
      3'd3:    alu_c = alu_a - alu_b;
      3'd4:    alu_c = alu_a ^ alu_b;
      3'd5:    alu_c = alu_a << alu_b[4:0];
      3'd6:    alu_c = {31'd0, (alu_a < alu_b)};
      default: alu_c = 32'd0;
    endcase
    alu_zero = (alu_c == 32'd0);
  end

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        zero;
    logic        err;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] c;
    logic        zero;
    logic        err;
    int          acc_cyc;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req_op[5:3]  = op;
      req_a[63:32] = a;
      req_b[63:32] = b;
    end else begin
      req_op[2:0]  = op;
      req_a[31:0]  = a;
      req_b[31:0]  = b;
    end
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_accept(output logic gid, output logic [1:0] rdy);
    logic seen;
    seen = 1'b0;
    gid  = 1'b0;
    rdy  = 2'b00;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        seen = 1'b1;
        gid  = req_ready[1];
        rdy  = req_ready;
      end
    end
    if (!seen) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_exp(input logic id, input logic [31:0] c, input logic zero, input logic err);
    exp_t e;
    e.id = id; e.c = c; e.zero = zero; e.err = err; e.acc_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic collect();
    logic seen;
    exp_t e;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) begin
      check("rsp_timeout", 64'd0, 64'd1);
    end else if (sb.size() == 0) begin
      check("unexpected_rsp", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("rsp_latency", 64'(cyc - e.acc_cyc), 64'd2);
      check("rsp_id",   64'(rsp_id),   64'(e.id));
      check("rsp_c",    64'(rsp_c),    64'(e.c));
      check("rsp_zero", 64'(rsp_zero), 64'(e.zero));
      check("rsp_err",  64'(rsp_err),  64'(e.err));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
    check({tag, "_rsp_c"},     64'(rsp_c),     64'd0);
    check({tag, "_rsp_zero"},  64'(rsp_zero),  64'd0);
    check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    check({tag, "_alu_op"},    64'(alu_op),    64'd0);
    check({tag, "_alu_a"},     64'(alu_a),     64'd0);
    check({tag, "_alu_b"},     64'(alu_b),     64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       gid;
    logic [1:0] rdy;
    logic       exp_gid;

    vecs[0] = '{1'b0, 3'd2, 32'd5,         32'd7,         32'd12,         1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'd3, 32'd9,         32'd9,         32'd0,          1'b1, 1'b0};
    vecs[2] = '{1'b1, 3'd7, 32'd3,         32'd4,         32'd0,          1'b0, 1'b1};
    vecs[3] = '{1'b1, 3'd0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 3'd1, 32'h0000_1200, 32'h0000_0034, 32'h0000_1234,  1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          1'b1, 1'b0};
    vecs[6] = '{1'b0, 3'd2, 32'hFFFF_FFFF, 32'd1,         32'd0,          1'b1, 1'b0};
    vecs[7] = '{1'b1, 3'd5, 32'd1,         32'd31,        32'h8000_0000,  1'b0, 1'b0};
    vecs[8] = '{1'b0, 3'd7, 32'd0,         32'd0,         32'd0,          1'b0, 1'b1};
    vecs[9] = '{1'b1, 3'd6, 32'd3,         32'd5,         32'd1,          1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single transactions
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_accept(gid, rdy);
      check("req_ready", 64'(rdy), vecs[i].id ? 64'd2 : 64'd1);
      push_exp(vecs[i].id, vecs[i].c, vecs[i].zero, vecs[i].err);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("exec_alu_op", 64'(alu_op), (vecs[i].op == 3'd7) ? 64'd0 : 64'(vecs[i].op));
      check("exec_alu_a",  64'(alu_a),  64'(vecs[i].a));
      check("exec_ready",  64'(req_ready), 64'd0);
      collect();
    end

    // Arbitration with both requesters held valid
    do_reset();
    @(posedge clk); #1;
    drive_req(1'b0, 3'd2, 32'd10, 32'd20);
    drive_req(1'b1, 3'd3, 32'd50, 32'd8);
    for (int k = 0; k < 4; k++) begin
      wait_accept(gid, rdy);
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_gid = 1'b0;
`else
      exp_gid = k[0];
`endif
      check("rr_grant", 64'(gid), 64'(exp_gid));
      check("rr_onehot", 64'($countones(rdy)), 64'd1);
      if (gid) push_exp(1'b1, 32'd42, 1'b0, 1'b0);
      else     push_exp(1'b0, 32'd30, 1'b0, 1'b0);
      collect();
    end
    @(posedge clk); #1;
    req_valid = 2'b00;

    // Response back-pressure: outputs hold, no new acceptance
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_req(1'b0, 3'd2, 32'd100, 32'd23);
    wait_accept(gid, rdy);
    check("stall_grant", 64'(gid), 64'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drive_req(1'b1, 3'd1, 32'd1, 32'd2);
    @(negedge clk);
    check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("stall_first_valid", 64'(rsp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_c",     64'(rsp_c),     64'd123);
      check("stall_id",    64'(rsp_id),    64'd0);
      check("stall_zero",  64'(rsp_zero),  64'd0);
      check("stall_err",   64'(rsp_err),   64'd0);
      check("stall_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_last_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    check("stall_released", 64'(rsp_valid), 64'd0);

    // Reset during EXEC discards the transaction
    @(posedge clk); #1;
    drive_req(1'b1, 3'd2, 32'd1, 32'd1);
    wait_accept(gid, rdy);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, 32, data width; SHALL equal the shared ALU operand width.
REQ-002 Ports SHALL be, in order:
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  request pending; bit i = requester i.
REQ-006 req_ready  output  2  request accepted this cycle; bit i = requester i.
REQ-007 req_op  input  6  op per requester; [2:0] req0, [5:3] req1.
REQ-008 req_a  input  2W  operand a; [W-1:0] req0, [2W-1:W] req1.
REQ-009 req_b  input  2W  operand b; same packing as req_a.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-012 rsp_id  output  1  requester the response belongs to.
REQ-013 rsp_c  output  W  result.
REQ-014 rsp_zero  output  1  result-equals-zero flag.
REQ-015 rsp_err  output  1  illegal op (7) flag.
REQ-016 alu_op  output  3  op to shared ALU.
REQ-017 alu_a  output  W  operand a to ALU.
REQ-018 alu_b  output  W  operand b to ALU.
REQ-019 alu_c  input  W  ALU result (combinational from alu_op/a/b).
REQ-020 alu_zero  input  1  ALU zero flag.

Function
REQ-021 FSM states SHALL be IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-022 IDLE: if any req_valid, grant one requester; req_ready[grant]=1 combinationally that cycle, all other req_ready bits 0; latch op/a/b/id into internal regs; go EXEC.
REQ-023 req_ready SHALL be 0 in EXEC and RESP; a request is accepted only in IDLE.
REQ-024 Arbitration SHALL be round-robin: both valid -> grant requester not granted last; one valid -> grant it; last-grant pointer updates on acceptance.
REQ-025 EXEC: alu_op/alu_a/alu_b driven from latched regs; alu_c/alu_zero captured into rsp_c/rsp_zero at cycle end; go RESP.
REQ-026 Latched op 7: ALU SHALL NOT be used (alu_op held 0); rsp_c=0, rsp_zero=0, rsp_err=1; otherwise rsp_err=0.
REQ-027 RESP: rsp_valid=1 with rsp_id/rsp_c/rsp_zero/rsp_err stable until rsp_ready=1; then go IDLE.
REQ-028 Latency: request accepted in cycle N -> rsp_valid first high in cycle N+2; minimum issue interval 3 cycles.
REQ-029 alu_op/alu_a/alu_b SHALL hold the last latched values outside EXEC (no toggling while idle).
REQ-030 rsp_valid SHALL be 0 in IDLE and EXEC; request deasserting after acceptance SHALL NOT affect the transaction.
REQ-031 rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, all outputs 0 (req_ready, rsp_*, alu_*), latched regs 0, last-grant pointer = 1 (req0 wins first tie).
REQ-033 Reset mid-transaction SHALL discard it; no response is produced after rst_n rises.

Configuration
REQ-034 Macro ALU_ARB_FIXED_PRIO_EN defined: arbitration SHALL be fixed priority, req0 always wins when both valid; pointer unused.
REQ-035 Macro undefined: round-robin per REQ-024.

Verification
REQ-036 req0 only, op=2, a=5, b=7 -> req_ready=2'b01 cycle N; cycle N+2 rsp_valid=1, rsp_id=0, rsp_c=12, rsp_zero=0, rsp_err=0.
REQ-037 req0 op=3 a=9 b=9 -> rsp_c=0, rsp_zero=1.
REQ-038 both valid continuously, rsp_ready=1 -> grants 0,1,0,1 (round-robin); with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-039 req1 op=7 -> alu_op stays 0, rsp_c=0, rsp_zero=0, rsp_err=1, rsp_id=1.
REQ-040 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready=0; rst_n pulsed low in EXEC -> all outputs 0, no response afterward.
